// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-input round-robin arbiter.
package rr_arb_pkg;

    localparam int N_IN = 4;

    typedef logic [1:0] sel_t;

    function automatic sel_t next_idx(input sel_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: first valid index at or after ptr.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_IN-1:0] valid,
    input  sel_t            ptr,
    output sel_t            grant_idx,
    output logic            any
);

    sel_t idx;

    // Walk from the farthest offset back to ptr so the nearest valid index wins.
    always_comb begin
        grant_idx = ptr;
        any       = 1'b0;
        idx       = ptr;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = ptr + sel_t'(k);
            if (valid[idx]) begin
                grant_idx = idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4_1.sv
// 4:1 round-robin arbiter with one registered output stage.
// Optional burst lock enabled by defining RR_ARB_BURST_LOCK_EN (adds in_last).
module rr_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in_valid,
    input  logic [W-1:0]    in_data [0:N_IN-1],
`ifdef RR_ARB_BURST_LOCK_EN
    input  logic [N_IN-1:0] in_last,
`endif
    output logic [N_IN-1:0] in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output sel_t            out_sel,
    output logic [W-1:0]    out_data
);

    sel_t ptr;
    sel_t ptr_next;
    sel_t pick_idx;
    logic pick_any;
    sel_t g;
    logic any_v;
    logic load_en;
    logic do_load;

    rr_pick_4 u_pick (
        .valid     (in_valid),
        .ptr       (ptr),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

`ifdef RR_ARB_BURST_LOCK_EN
    logic lock;
    sel_t lock_idx;

    // While locked, only the burst owner may be granted.
    always_comb begin
        g     = pick_idx;
        any_v = pick_any;
        if (lock) begin
            g     = lock_idx;
            any_v = in_valid[lock_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (do_load) begin
            lock     <= ~in_last[g];
            lock_idx <= g;
        end
    end

    // Pointer only moves once a burst (or single word) has finished.
    always_comb begin
        ptr_next = ptr;
        if (do_load && in_last[g])
            ptr_next = next_idx(g);
    end
`else
    always_comb begin
        g     = pick_idx;
        any_v = pick_any;
    end

    always_comb begin
        ptr_next = ptr;
        if (do_load)
            ptr_next = next_idx(g);
    end
`endif

    assign load_en  = ~out_valid | out_ready;
    assign do_load  = load_en & any_v & ~rst;
    assign in_ready = do_load ? (N_IN'(1) << g) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
            out_data  <= '0;
            ptr       <= '0;
        end else begin
            ptr <= ptr_next;
            if (do_load) begin
                out_valid <= 1'b1;
                out_sel   <= g;
                out_data  <= in_data[g];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed self-checking bench for rr_arb_4_1 (burst-lock test when RR_ARB_BURST_LOCK_EN is defined).
module tb_rr_arb_4_1;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_data [0:3];
`ifdef RR_ARB_BURST_LOCK_EN
    logic [3:0] in_last;
`endif
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sel;
    logic [3:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arb_4_1 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_ARB_BURST_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_comb: got %b want 0000", in_ready);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid);
            end
            n_checks++;
            if (out_sel !== 2'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_sel cyc%0d: got %0d want 0", c, out_sel);
            end
            n_checks++;
            if (out_data !== 4'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_data cyc%0d: got %0d want 0", c, out_data);
            end
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL reset_in_ready cyc%0d: got %b want 0000", c, in_ready);
            end
        end
    endtask

    task automatic test_rotation;
        logic [3:0] exp_rdy;
        logic [1:0] exp_sel;
        logic [3:0] exp_data;
        rst = 1'b0;
        in_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_sel  = 2'(k % 4);
            exp_rdy  = 4'b0001 << exp_sel;
            exp_data = 4'(k % 4 + 1);
            #1;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("[TB] FAIL rot_in_ready step%0d: got %b want %b", k, in_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data) begin
                n_fail++;
                $display("[TB] FAIL rot_out step%0d: got v=%b sel=%0d data=%0d want v=1 sel=%0d data=%0d",
                         k, out_valid, out_sel, out_data, exp_sel, exp_data);
            end
        end
    endtask

    task automatic test_skip;
        logic [1:0] exp_g [0:2];
        logic [3:0] exp_rdy;
        exp_g[0] = 2'd1;
        exp_g[1] = 2'd3;
        exp_g[2] = 2'd1;
        rst = 1'b1;
        in_valid = 4'b0000;
        tick();
        rst = 1'b0;
        in_valid = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_rdy = 4'b0001 << exp_g[k];
            #1;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("[TB] FAIL skip_in_ready step%0d: got %b want %b", k, in_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_g[k] || out_data !== 4'(exp_g[k]) + 4'd1) begin
                n_fail++;
                $display("[TB] FAIL skip_out step%0d: got v=%b sel=%0d data=%0d want v=1 sel=%0d data=%0d",
                         k, out_valid, out_sel, out_data, exp_g[k], 4'(exp_g[k]) + 4'd1);
            end
        end
    endtask

    task automatic test_stall;
        in_valid = 4'hF;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL stall_in_ready cyc%0d: got %b want 0000", c, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'd2) begin
                n_fail++;
                $display("[TB] FAIL stall_hold cyc%0d: got v=%b sel=%0d data=%0d want v=1 sel=1 data=2",
                         c, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL release_in_ready: got %b want 0100", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL release_load: got v=%b sel=%0d data=%0d want v=1 sel=2 data=3",
                     out_valid, out_sel, out_data);
        end
        in_valid = 4'b0000;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL drain_in_ready: got %b want 0000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL drain_out: got v=%b sel=%0d data=%0d want v=0 sel=2 data=3",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_reset_mid;
        in_valid = 4'hF;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL pre_rst_in_ready: got %b want 1000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'd4) begin
            n_fail++;
            $display("[TB] FAIL pre_rst_load: got v=%b sel=%0d data=%0d want v=1 sel=3 data=4",
                     out_valid, out_sel, out_data);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL mid_rst_in_ready: got %b want 0000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_rst_out: got v=%b sel=%0d data=%0d want v=0 sel=0 data=0",
                     out_valid, out_sel, out_data);
        end
        rst = 1'b0;
        in_valid = 4'b0110;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL post_rst_in_ready: got %b want 0010", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'd2) begin
            n_fail++;
            $display("[TB] FAIL post_rst_load: got v=%b sel=%0d data=%0d want v=1 sel=1 data=2",
                     out_valid, out_sel, out_data);
        end
    endtask

`ifdef RR_ARB_BURST_LOCK_EN
    task automatic test_burst_lock;
        logic [3:0] last_vec [0:3];
        logic [1:0] exp_sel  [0:3];
        logic [3:0] exp_rdy;
        last_vec[0] = 4'b1011; exp_sel[0] = 2'd2;
        last_vec[1] = 4'b1011; exp_sel[1] = 2'd2;
        last_vec[2] = 4'b1111; exp_sel[2] = 2'd2;
        last_vec[3] = 4'b1111; exp_sel[3] = 2'd3;
        rst = 1'b1;
        in_last = 4'hF;
        in_valid = 4'b0000;
        tick();
        rst = 1'b0;
        in_valid = 4'b0011;
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_last = last_vec[k];
            exp_rdy = 4'b0001 << exp_sel[k];
            #1;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("[TB] FAIL burst_in_ready word%0d: got %b want %b", k, in_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[k]) begin
                n_fail++;
                $display("[TB] FAIL burst_sel word%0d: got v=%b sel=%0d want v=1 sel=%0d",
                         k, out_valid, out_sel, exp_sel[k]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 1);
        rst = 1'b1;
        in_valid = 4'b0000;
        out_ready = 1'b0;
`ifdef RR_ARB_BURST_LOCK_EN
        in_last = 4'hF;
`endif
        test_reset();
        test_rotation();
        test_skip();
        test_stall();
        test_reset_mid();
`ifdef RR_ARB_BURST_LOCK_EN
        test_burst_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
